// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch port: the sequencer requests IAddr, memory answers with IReady.
interface pc_sequencer_if #(
  parameter int PC_WIDTH = 32
);
  logic                IReq;
  logic [PC_WIDTH-1:0] IAddr;
  logic                IReady;

  modport master (output IReq, output IAddr, input IReady);
  modport slave  (input IReq, input IAddr, output IReady);
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches each instruction over a req/ready port and
// applies the 2-bit JumpOP (seq / branch / jr / jump) when the instruction retires.
module pc_sequencer #(
  parameter int          PC_WIDTH = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          JumpOP,
  input  logic [15:0]         BranchOffset,
  input  logic [25:0]         JumpAddr,
  input  logic [PC_WIDTH-1:0] JrAddr,
  input  logic                Stall,
  pc_sequencer_if.master      imem,
  output logic [PC_WIDTH-1:0] PC,
  output logic [PC_WIDTH-1:0] PCPlus4,
  output logic                InstrValid,
  output logic                AlignErr,
  output logic [15:0]         RedirectCount
);

  localparam logic [PC_WIDTH-1:0] RESET_PC_W = RESET_PC[PC_WIDTH-1:0];

  typedef enum logic [1:0] {BOOT, FETCH, WAIT, EXEC} state_t;

  state_t              state_reg, state_next;
  logic [PC_WIDTH-1:0] pc_reg, pc_next;
  logic                align_err_reg, align_err_next;
  logic [15:0]         redirect_count_reg, redirect_count_next;

  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] branch_disp;
  logic [PC_WIDTH-1:0] branch_target;
  logic [PC_WIDTH-1:0] jr_target;
  logic [PC_WIDTH-1:0] jump_target;
  logic [PC_WIDTH-1:0] redirect_pc;

  assign pc_plus4      = pc_reg + PC_WIDTH'(4);
  assign branch_disp   = {{(PC_WIDTH-18){BranchOffset[15]}}, BranchOffset, 2'b00};
  assign branch_target = pc_plus4 + branch_disp;
  assign jr_target     = {JrAddr[PC_WIDTH-1:2], 2'b00};

  // A 28-bit address space is fully covered by the J-type field, so no region bits remain.
  generate
    if (PC_WIDTH > 28) begin : g_jump_region
      assign jump_target = {pc_plus4[PC_WIDTH-1:28], JumpAddr, 2'b00};
    end else begin : g_jump_flat
      assign jump_target = {JumpAddr, 2'b00};
    end
  endgenerate

  always_comb begin
    redirect_pc = pc_plus4;
    case (JumpOP)
      2'b01:   redirect_pc = branch_target;
      2'b10:   redirect_pc = jr_target;
      2'b11:   redirect_pc = jump_target;
      default: redirect_pc = pc_plus4;
    endcase
  end

  always_comb begin
    state_next          = state_reg;
    pc_next             = pc_reg;
    align_err_next      = 1'b0;
    redirect_count_next = redirect_count_reg;
    case (state_reg)
      BOOT:  state_next = FETCH;
      FETCH: state_next = imem.IReady ? EXEC : WAIT;
      WAIT:  if (imem.IReady) state_next = EXEC;
      EXEC: begin
        // Jump-control inputs only matter on the retiring cycle; stalled cycles ignore them.
        if (!Stall) begin
          state_next     = FETCH;
          pc_next        = redirect_pc;
          align_err_next = (JumpOP == 2'b10) && (JrAddr[1:0] != 2'b00);
          if ((JumpOP != 2'b00) && (redirect_count_reg != 16'hFFFF))
            redirect_count_next = redirect_count_reg + 16'd1;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= BOOT;
      pc_reg             <= RESET_PC_W;
      align_err_reg      <= 1'b0;
      redirect_count_reg <= 16'h0000;
    end else begin
      state_reg          <= state_next;
      pc_reg             <= pc_next;
      align_err_reg      <= align_err_next;
      redirect_count_reg <= redirect_count_next;
    end
  end

  assign imem.IReq     = (state_reg == FETCH) || (state_reg == WAIT);
  assign imem.IAddr    = pc_reg;
  assign PC            = pc_reg;
  assign PCPlus4       = pc_plus4;
  assign InstrValid    = (state_reg == EXEC);
  assign AlignErr      = align_err_reg;
  assign RedirectCount = redirect_count_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed and random instructions checked against an arithmetic PC model.
module tb_pc_sequencer;
  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  JumpOP;
  logic [15:0] BranchOffset;
  logic [25:0] JumpAddr;
  logic [31:0] JrAddr;
  logic        Stall;
  logic [31:0] PC, PCPlus4;
  logic        InstrValid, AlignErr;
  logic [15:0] RedirectCount;

  always #5 clk = ~clk;

  pc_sequencer_if #(.PC_WIDTH(W)) imem_if ();

  pc_sequencer #(.PC_WIDTH(W), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .JumpOP       (JumpOP),
    .BranchOffset (BranchOffset),
    .JumpAddr     (JumpAddr),
    .JrAddr       (JrAddr),
    .Stall        (Stall),
    .imem         (imem_if),
    .PC           (PC),
    .PCPlus4      (PCPlus4),
    .InstrValid   (InstrValid),
    .AlignErr     (AlignErr),
    .RedirectCount(RedirectCount)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_pc;
  int unsigned m_cnt;
  logic        preload_sat = 1'b0;
  int          n_instr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_next(input logic [1:0] op, input logic [31:0] pc,
                                           input logic [15:0] boff, input logic [25:0] jaddr,
                                           input logic [31:0] jr);
    logic [31:0] seq;
    int          words;
    seq   = pc + 32'd4;
    words = int'($signed(boff));
    case (op)
      2'd1:    return seq + 32'(words * 4);
      2'd2:    return jr & ~32'h3;
      2'd3:    return (seq & 32'hF000_0000) | (32'(jaddr) * 4);
      default: return seq;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic scramble();
    JumpOP       = 2'($urandom);
    BranchOffset = 16'($urandom);
    JumpAddr     = 26'($urandom);
    JrAddr       = $urandom;
  endtask

  // Starts and ends at a negedge with the DUT in FETCH.
  task automatic run_instr(input int waits, input int stalls, input logic [1:0] op,
                           input logic [15:0] boff, input logic [25:0] jaddr, input logic [31:0] jr);
    logic [31:0] exp_next;
    logic        exp_align;
    check("fetch_ireq", 32'(imem_if.IReq), 32'd1);
    check("fetch_iaddr", imem_if.IAddr, m_pc);
    check("fetch_pc", PC, m_pc);
    check("fetch_valid", 32'(InstrValid), 32'd0);
    check("pcplus4", PCPlus4, m_pc + 32'd4);
    imem_if.IReady = (waits == 0);
    Stall = 1'($urandom);
    scramble();
    if (preload_sat) force dut.redirect_count_reg = 16'hFFFD;
    step();
    if (preload_sat) begin
      release dut.redirect_count_reg;
      m_cnt       = 32'hFFFD;
      preload_sat = 1'b0;
    end
    for (int w = 1; w <= waits; w++) begin
      check("wait_ireq", 32'(imem_if.IReq), 32'd1);
      check("wait_iaddr", imem_if.IAddr, m_pc);
      check("wait_valid", 32'(InstrValid), 32'd0);
      check("wait_alignerr", 32'(AlignErr), 32'd0);
      imem_if.IReady = (w == waits);
      scramble();
      step();
    end
    imem_if.IReady = 1'($urandom);
    check("exec_valid", 32'(InstrValid), 32'd1);
    check("exec_ireq", 32'(imem_if.IReq), 32'd0);
    check("exec_pc", PC, m_pc);
    check("exec_alignerr", 32'(AlignErr), 32'd0);
    check("exec_redirects", 32'(RedirectCount), m_cnt);
    for (int s = 0; s < stalls; s++) begin
      Stall = 1'b1;
      scramble();
      step();
      check("stall_valid", 32'(InstrValid), 32'd1);
      check("stall_pc", PC, m_pc);
      check("stall_redirects", 32'(RedirectCount), m_cnt);
    end
    Stall        = 1'b0;
    JumpOP       = op;
    BranchOffset = boff;
    JumpAddr     = jaddr;
    JrAddr       = jr;
    step();
    exp_next  = ref_next(op, m_pc, boff, jaddr, jr);
    exp_align = (op == 2'd2) && (jr[1:0] != 2'b00);
    if (op != 2'd0 && m_cnt < 32'hFFFF) m_cnt++;
    check("next_pc", PC, exp_next);
    check("alignerr", 32'(AlignErr), 32'(exp_align));
    check("redirects", 32'(RedirectCount), m_cnt);
    $display("instr %0d pc=%h op=%0d waits=%0d stalls=%0d next=%h redirects=%0d",
             n_instr, m_pc, op, waits, stalls, exp_next, m_cnt);
    n_instr++;
    m_pc = exp_next;
    scramble();
  endtask

  // Leaves the DUT in FETCH at a negedge.
  task automatic do_reset(input int cycles);
    rst = 1'b1;
    imem_if.IReady = 1'($urandom);
    repeat (cycles) step();
    check("rst_ireq", 32'(imem_if.IReq), 32'd0);
    check("rst_valid", 32'(InstrValid), 32'd0);
    check("rst_pc", PC, 32'h0);
    check("rst_alignerr", 32'(AlignErr), 32'd0);
    check("rst_redirects", 32'(RedirectCount), 32'd0);
    rst = 1'b0;
    step();
    m_pc  = 32'h0;
    m_cnt = 0;
  endtask

  initial begin
    rst            = 1'b1;
    Stall          = 1'b0;
    imem_if.IReady = 1'b0;
    scramble();
    @(negedge clk);
    do_reset(2);

    repeat (3) run_instr(0, 0, 2'd0, 16'h0, 26'h0, 32'h0);
    run_instr(0, 0, 2'd3, 16'h0, 26'h0000040, 32'h0);     // 0xC -> 0x100
    run_instr(0, 0, 2'd1, 16'hFFFE, 26'h0, 32'h0);        // 0x100 -> 0xFC
    run_instr(0, 0, 2'd3, 16'h0, 26'h0000040, 32'h0);     // back to 0x100
    run_instr(0, 0, 2'd1, 16'h0003, 26'h0, 32'h0);        // 0x100 -> 0x110
    run_instr(0, 0, 2'd2, 16'h0, 26'h0, 32'hF000_0010);
    run_instr(0, 0, 2'd3, 16'h0, 26'h0000040, 32'h0);     // 0xF0000010 -> 0xF0000100
    run_instr(0, 0, 2'd2, 16'h0, 26'h0, 32'h0000_0203);   // misaligned jr -> 0x200
    run_instr(3, 2, 2'd3, 16'h0, 26'h0000080, 32'h0);
    run_instr(0, 0, 2'd1, 16'hFFFF, 26'h0, 32'h0);        // self-loop
    run_instr(1, 0, 2'd1, 16'hFFFF, 26'h0, 32'h0);

    // Reset lands in WAIT on the same edge IReady rises: the fetch must be dropped.
    imem_if.IReady = 1'b0;
    step();
    check("midrst_wait_ireq", 32'(imem_if.IReq), 32'd1);
    rst = 1'b1;
    imem_if.IReady = 1'b1;
    step();
    check("midrst_valid", 32'(InstrValid), 32'd0);
    check("midrst_pc", PC, 32'h0);
    check("midrst_ireq", 32'(imem_if.IReq), 32'd0);
    check("midrst_redirects", 32'(RedirectCount), 32'd0);
    step();
    check("midrst_valid_hold", 32'(InstrValid), 32'd0);
    rst = 1'b0;
    imem_if.IReady = 1'b0;
    step();
    m_pc  = 32'h0;
    m_cnt = 0;

    for (int i = 0; i < 150; i++) begin
      run_instr(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 2'($urandom),
                16'($urandom), 26'($urandom), $urandom);
    end

    preload_sat = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_instr(int'($urandom_range(0, 1)), 0, 2'd1 + 2'($urandom_range(0, 2)),
                16'($urandom), 26'($urandom), $urandom);
    end
    run_instr(0, 0, 2'd0, 16'h0, 26'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
